// File: rtl/emmc_pkg.sv
// ---------------------------------------------------------------------------
// emmc_pkg
// Shared definitions for the eMMC command transmitter: frame geometry,
// the CRC7 polynomial and a single-bit CRC7 step, bit-counter milestones
// and the transmit FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package emmc_pkg;

  localparam int CMD_FRAME_BITS = 48;
  localparam int CMD_HDR_BITS   = 40;
  localparam int CRC7_BITS      = 7;

  // x^7 + x^3 + 1 with the x^7 term implied by the shift.
  localparam logic [CRC7_BITS-1:0] CRC7_POLY = 7'h09;

  // Fixed-value bits of the frame: start (bit 47), transmission (bit 46),
  // end (bit 0).
  localparam logic FRAME_START_BIT = 1'b0;
  localparam logic FRAME_TX_BIT    = 1'b1;
  localparam logic FRAME_END_BIT   = 1'b1;

  // Bit-counter values at which the FSM changes phase. The counter holds
  // the index of the frame bit about to be driven (0 = start bit).
  localparam logic [5:0] HDR_LAST_CNT  = 6'(CMD_HDR_BITS - 1);
  localparam logic [5:0] CRC_FIRST_CNT = 6'(CMD_HDR_BITS);
  localparam logic [5:0] CRC_LAST_CNT  = 6'(CMD_FRAME_BITS - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CRC,
    ST_END,
    ST_GAP
  } cmd_state_e;

  // One serial CRC7 step: feedback is the incoming bit XOR the CRC MSB.
  function automatic logic [CRC7_BITS-1:0] crc7_step(input logic [CRC7_BITS-1:0] crc,
                                                     input logic bitval);
    logic fb;
    fb = bitval ^ crc[CRC7_BITS-1];
    return {crc[CRC7_BITS-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/emmc_cmd_crc7.sv
// ---------------------------------------------------------------------------
// emmc_cmd_crc7
// Serial CRC7 LFSR (x^7 + x^3 + 1, seed 0). Advances one bit per enabled
// cycle and clears synchronously when a new command is accepted. Once the
// header has gone out the register simply holds, which makes it the CRC
// snapshot used for the CRC field and for CRC_OUT.
// Ports:
//   CLK, RSTN  clock / async active-low reset
//   BITVAL     data bit being transmitted
//   ENABLE     advance the CRC on BITVAL this cycle
//   CLEAR      reset the CRC to zero (has priority over ENABLE)
//   CRC        current CRC7 value
// ---------------------------------------------------------------------------
module emmc_cmd_crc7
  import emmc_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 BITVAL,
  input  logic                 ENABLE,
  input  logic                 CLEAR,
  output logic [CRC7_BITS-1:0] CRC
);

  logic [CRC7_BITS-1:0] crc_q;
  logic [CRC7_BITS-1:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (CLEAR) begin
      crc_d = '0;
    end else if (ENABLE) begin
      crc_d = crc7_step(crc_q, BITVAL);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign CRC = crc_q;

endmodule

// File: rtl/emmc_cmd_tx.sv
// ---------------------------------------------------------------------------
// emmc_cmd_tx
// Serialises one 48-bit eMMC command token onto the CMD line, MSB first,
// one bit per CMD_TICK, generating CRC7 on the fly, then holds the line
// released for GAP_BITS ticks before accepting the next command.
// Ports:
//   CLK, RSTN   clock / async active-low reset
//   CMD_TICK    one-cycle bit-rate enable
//   START       send request, sampled only while idle
//   CMD_INDEX   6-bit command index (latched on accept)
//   CMD_ARG     32-bit argument (latched on accept)
//   BUSY        high from accept until the gap completes
//   DONE        one-cycle pulse on the edge the end bit is driven
//   CMD_OUT     serial CMD data
//   CMD_OE      CMD pad output enable
//   CRC_OUT     CRC7 of the last completed command
// ---------------------------------------------------------------------------
module emmc_cmd_tx
  import emmc_pkg::*;
#(
  parameter int GAP_BITS = 8
)
(
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 CMD_TICK,
  input  logic                 START,
  input  logic [5:0]           CMD_INDEX,
  input  logic [31:0]          CMD_ARG,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 CMD_OUT,
  output logic                 CMD_OE,
  output logic [CRC7_BITS-1:0] CRC_OUT
);

  localparam logic [7:0] GAP_LAST_CNT = 8'(GAP_BITS - 1);

  cmd_state_e              state_q,   state_d;
  logic [CMD_HDR_BITS-1:0] shift_q,   shift_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              gap_cnt_q, gap_cnt_d;
  logic                    busy_q,    busy_d;
  logic                    done_q,    done_d;
  logic                    cmd_out_q, cmd_out_d;
  logic                    cmd_oe_q,  cmd_oe_d;
  logic [CRC7_BITS-1:0]    crc_out_q, crc_out_d;

  logic                    crc_clear;
  logic                    crc_en;
  logic [CRC7_BITS-1:0]    crc_val;
  logic [2:0]              crc_idx;

  // The CRC clears on accept and only advances on header ticks, so from
  // HDR exit until the next accept it holds the finished CRC.
  assign crc_clear = (state_q == ST_IDLE) && START;
  assign crc_en    = (state_q == ST_HDR) && CMD_TICK;

  emmc_cmd_crc7 u_crc7 (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .BITVAL (shift_q[CMD_HDR_BITS-1]),
    .ENABLE (crc_en),
    .CLEAR  (crc_clear),
    .CRC    (crc_val)
  );

  // Position within the CRC field, 0 for its MSB.
  assign crc_idx = 3'(bit_cnt_q - CRC_FIRST_CNT);

  // Next-state logic. Every output is registered and only moves on a
  // CMD_TICK edge, except BUSY which rises on the accept edge itself. The
  // accept edge never consumes a coincident tick because the FSM is still
  // in IDLE on that edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cmd_out_d = cmd_out_q;
    cmd_oe_d  = cmd_oe_q;
    crc_out_d = crc_out_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          shift_d   = {FRAME_START_BIT, FRAME_TX_BIT, CMD_INDEX, CMD_ARG};
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (CMD_TICK) begin
          cmd_oe_d  = 1'b1;
          cmd_out_d = shift_q[CMD_HDR_BITS-1];
          shift_d   = {shift_q[CMD_HDR_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == HDR_LAST_CNT) begin
            state_d = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (CMD_TICK) begin
          cmd_out_d = crc_val[3'd6 - crc_idx];
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == CRC_LAST_CNT) begin
            state_d = ST_END;
          end
        end
      end
      ST_END: begin
        if (CMD_TICK) begin
          cmd_out_d = FRAME_END_BIT;
          done_d    = 1'b1;
          crc_out_d = crc_val;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (CMD_TICK) begin
          cmd_oe_d  = 1'b0;
          cmd_out_d = 1'b1;
          gap_cnt_d = gap_cnt_q + 8'd1;
          if (gap_cnt_q == GAP_LAST_CNT) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset releases the line at once, so a
  // frame interrupted by reset ends without an end bit.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      crc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cmd_out_q <= cmd_out_d;
      cmd_oe_q  <= cmd_oe_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign CMD_OUT = cmd_out_q;
  assign CMD_OE  = cmd_oe_q;
  assign CRC_OUT = crc_out_q;

endmodule

// File: doc/emmc_cmd_tx.md
Name: emmc_cmd_tx

Overview:
Serialises one eMMC command token (48 bits) onto the CMD line and generates the CRC7 field on the fly, one bit per bit-rate tick. Sits between the command sequencer (upstream: index/argument + START strobe) and the CMD pad (downstream: CMD_OUT/CMD_OE). After the end bit it enforces a minimum idle gap (Ncc) on the line before accepting the next command.

Parameters:
GAP_BITS, 8, number of CMD_TICK periods the line is released after the end bit before BUSY drops (legal range 1..255).

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
RSTN  input  1  asynchronous active-low reset.
CMD_TICK  input  1  one-CLK-wide bit-rate enable; one CMD bit is emitted per tick.
START  input  1  request to send; sampled only while BUSY=0.
CMD_INDEX  input  6  command index, latched on accept.
CMD_ARG  input  32  command argument, latched on accept.
BUSY  output  1  high from accept until gap complete.
DONE  output  1  one-CLK pulse when the end bit has been driven.
CMD_OUT  output  1  serial CMD data, MSB first.
CMD_OE  output  1  CMD pad output enable.
CRC_OUT  output  7  CRC7 of the last transmitted command; stable in IDLE.

Behaviour:
- Reset (RSTN=0, async): state IDLE, BUSY=0, DONE=0, CMD_OUT=1, CMD_OE=0, CRC_OUT=0, bit counter 0, shift register cleared. Reset mid-frame aborts immediately: the line is released with no end bit.
- Frame: bit47 start=0, bit46 transmission=1, bits45:40 CMD_INDEX, bits39:8 CMD_ARG, bits7:1 CRC7, bit0 end=1.
- CRC7: polynomial x^7+x^3+1, seed 0, computed over bits 47..8 as they are shifted out. Feedback bit is data XOR crc[6]. Next state: crc[3] gets crc[2] XOR fb, crc[0] gets fb, all other bits shift up.
- FSM states: IDLE, HDR, CRC, END, GAP.
- IDLE: START=1 at any CLK edge, independent of CMD_TICK. The block latches {0,1,INDEX,ARG} into a 40-bit shift register, clears the CRC, sets BUSY=1 on the same edge, and goes to HDR. CMD_OE stays 0 until the first tick.
- HDR: on each CMD_TICK, CMD_OE=1, CMD_OUT = shift MSB, the CRC advances on that bit, and the shift register shifts left. After 40 ticks go to CRC.
- CRC: on each of 7 ticks, drive CRC MSB first, taken from a 7-bit snapshot captured at HDR exit. Then go to END.
- END: on the next tick drive 1 and pulse DONE on that same edge. CRC_OUT takes the snapshot. Go to GAP.
- GAP: on the first tick CMD_OE=0 and CMD_OUT=1. Count GAP_BITS ticks, then clear BUSY on that edge and return to IDLE.
- Latency: the start bit appears on the first CMD_TICK after accept. If CMD_TICK and START coincide on the accept edge, that tick is not consumed, so the start bit appears on the following tick. Frame = 48 ticks, plus GAP_BITS ticks of gap.
- Outputs change only on CMD_TICK edges, except BUSY (on accept) and reset. Between ticks CMD_OUT/CMD_OE hold.
- START while BUSY=1 is ignored and has no queueing. START in the same cycle BUSY falls is ignored. It is accepted the next cycle if still high.
- INDEX/ARG changes after accept have no effect on the frame in flight.
- Bit counter is 6 bits and never wraps within a frame. The gap counter is 8 bits.

Decomposition:
- Shared package emmc_pkg:
  - CMD_FRAME_BITS=48, CMD_HDR_BITS=40, CRC7_BITS=7.
  - CRC7 polynomial constant 7'h09.
  - FSM state encoding: IDLE/HDR/CRC/END/GAP.
  - Frame bit-position constants.
- One sub-module: emmc_cmd_crc7. It is a synchronous, tick-enabled, clear-on-start CRC7 LFSR on CLK/RSTN, with inputs BITVAL, ENABLE, CLEAR and a 7-bit CRC output.

Test Plan:
- CMD0, ARG=32'h0 -> serial capture 48'h40_0000_0000_95; CRC_OUT=7'h4A; DONE pulses once, on the 48th tick; BUSY low exactly GAP_BITS ticks later.
- CMD17, ARG=32'h0 -> frame 48'h51_0000_0000_55; CRC_OUT=7'h2A.
- CMD8, ARG=32'h0000_01AA -> frame 48'h48_0000_01AA_87; CRC_OUT=7'h43. Run with CMD_TICK every 4 CLKs, and separately with continuous CMD_TICK; both give identical bit sequences.
- START re-asserted during HDR with CMD_INDEX=6'd55 -> ignored; the in-flight frame is unchanged and no second frame starts until IDLE.
- RSTN pulled low at tick 20 of a frame -> CMD_OE=0, CMD_OUT=1, BUSY=0, DONE=0 immediately. The next START after release sends a full, correct frame.
- Back-to-back: START held high continuously -> successive frames are separated by exactly GAP_BITS released ticks plus one accept cycle, each with a correct CRC.
